// File: rtl/traffic_pkg.sv
// Shared types and helpers for the junction phase controller.
//   phase_t        : controller phases
//   lamp_t         : one approach's lamp triple
//   idx_width      : width of an approach index (at least 1 bit)
//   phase_duration : cycle count a phase lasts, picked from the duration set
package traffic_pkg;

  typedef enum logic [2:0] {
    MAJ_G,
    MAJ_A,
    CLR1,
    MIN_G,
    MIN_A,
    CLR2,
    FLASH
  } phase_t;

  typedef struct packed {
    logic red;
    logic amber;
    logic green;
  } lamp_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FLASH reuses the phase timer as the flash half-period counter.
  function automatic int phase_duration(input phase_t p, input int maj_g,
                                        input int min_g, input int amber,
                                        input int all_red, input int flash_half);
    case (p)
      MAJ_G:        return maj_g;
      MAJ_A, MIN_A: return amber;
      CLR1, CLR2:   return all_red;
      MIN_G:        return min_g;
      default:      return flash_half;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over N requests.
//   req       : request vector
//   last      : index served most recently; scan starts at last+1
//   grant_idx : first set request found, wrapping modulo N (holds last if none)
//   any       : at least one request is set
module rr_arbiter
  import traffic_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    j         = 0;
    grant_idx = last;
    any       = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!any && req[IW'(j)]) begin
        any       = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Junction controller: one major road plus N_MINOR minor approaches.
// Internal phase timer, sticky car requests, round-robin minor service with a
// mandatory return to major green between minor greens, all-red clearance and
// a flashing-amber maintenance mode. Lamps are decoded from registered state.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   car[N_MINOR]             : per-approach vehicle request (level or pulse)
//   flash                    : maintenance flashing-amber request (level)
//   major_green/amber/red    : major road lamps
//   minor_green/amber/red[N] : minor approach lamps
//   pending[N]               : latched requests awaiting service
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_MINOR         = 2,
  parameter int CW              = 8,
  parameter int MIN_MAJOR_GREEN = 10,
  parameter int MINOR_GREEN     = 8,
  parameter int AMBER           = 3,
  parameter int ALL_RED         = 1,
  parameter int FLASH_HALF      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_MINOR-1:0] car,
  input  logic               flash,
  output logic               major_green,
  output logic               major_amber,
  output logic               major_red,
  output logic [N_MINOR-1:0] minor_green,
  output logic [N_MINOR-1:0] minor_amber,
  output logic [N_MINOR-1:0] minor_red,
  output logic [N_MINOR-1:0] pending
);

  localparam int     IW   = idx_width(N_MINOR);
  localparam longint TMAX = longint'(1) << CW;

  if (N_MINOR < 1 ||
      MIN_MAJOR_GREEN < 1 || longint'(MIN_MAJOR_GREEN) > TMAX ||
      MINOR_GREEN < 1     || longint'(MINOR_GREEN) > TMAX ||
      AMBER < 1           || longint'(AMBER) > TMAX ||
      ALL_RED < 1         || longint'(ALL_RED) > TMAX ||
      FLASH_HALF < 1      || longint'(FLASH_HALF) > TMAX) begin : g_param_check
    $error("traffic_phase_ctrl: N_MINOR must be >= 1 and every duration in 1..2**CW");
  end

  phase_t             state, next_state;
  logic [CW-1:0]      timer;
  logic [IW-1:0]      sel, last_served, grant_idx;
  logic [N_MINOR-1:0] pending_next, sel_mask;
  logic               grant_any, flash_on;
  lamp_t              major;

  rr_arbiter #(.N(N_MINOR)) u_arb (
    .req      (pending),
    .last     (last_served),
    .grant_idx(grant_idx),
    .any      (grant_any)
  );

  always_comb begin
    sel_mask   = N_MINOR'(1) << sel;
    next_state = state;
    case (state)
      MAJ_G: if (flash) next_state = FLASH;
             else if (timer == '0 && grant_any) next_state = MAJ_A;
      MAJ_A: if (timer == '0) next_state = CLR1;
      CLR1:  if (timer == '0) next_state = MIN_G;
      MIN_G: if (timer == '0) next_state = MIN_A;
      MIN_A: if (timer == '0) next_state = CLR2;
      CLR2:  if (timer == '0) next_state = flash ? FLASH : MAJ_G;
      FLASH: if (!flash) next_state = CLR2;
      default: next_state = MAJ_G;
    endcase

    // The approach being served cannot re-request while its green is showing.
    pending_next = pending | ((state == MIN_G) ? (car & ~sel_mask) : car);
    if (next_state == MIN_G) pending_next = pending_next & ~sel_mask;

    major       = '{red: 1'b1, amber: 1'b0, green: 1'b0};
    minor_green = '0;
    minor_amber = '0;
    minor_red   = '1;
    case (state)
      MAJ_G: major = '{red: 1'b0, amber: 1'b0, green: 1'b1};
      MAJ_A: major = '{red: 1'b0, amber: 1'b1, green: 1'b0};
      MIN_G: begin
        minor_green = sel_mask;
        minor_red   = ~sel_mask;
      end
      MIN_A: begin
        minor_amber = sel_mask;
        minor_red   = ~sel_mask;
      end
      FLASH: begin
        major       = '{red: 1'b0, amber: flash_on, green: 1'b0};
        minor_amber = {N_MINOR{flash_on}};
        minor_red   = '0;
      end
      default: ;
    endcase
  end

  assign major_green = major.green;
  assign major_amber = major.amber;
  assign major_red   = major.red;

  // Phase register stage: state, timer, service bookkeeping, flash phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= MAJ_G;
      timer       <= CW'(MIN_MAJOR_GREEN - 1);
      sel         <= IW'(N_MINOR - 1);
      last_served <= IW'(N_MINOR - 1);
      pending     <= '0;
      flash_on    <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= pending_next;
      if (next_state != state) begin
        timer <= CW'(phase_duration(next_state, MIN_MAJOR_GREEN, MINOR_GREEN,
                                    AMBER, ALL_RED, FLASH_HALF) - 1);
        if (next_state == FLASH) flash_on <= 1'b1;
      end else if (state == FLASH && timer == '0) begin
        timer    <= CW'(FLASH_HALF - 1);
        flash_on <= ~flash_on;
      end else if (timer != '0) begin
        timer <= timer - CW'(1);
      end
      if (state == MAJ_G && next_state == MAJ_A) sel <= grant_idx;
      if (state == CLR1 && next_state == MIN_G) last_served <= sel;
    end
  end

endmodule
